// File: rtl/vector_assembler.sv
// Rebuilds an 8-bit vector from four framed fields (4,2,1,1 bits, MSB field first)
// and presents it on a one-word buffered valid/ready output.
module vector_assembler #(
  parameter bit CHECK_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fld_valid,
  input  logic [3:0] fld_data,
  input  logic       fld_first,
  output logic       fld_ready,
  output logic       out_valid,
  output logic [7:0] out_vec,
  input  logic       out_ready,
  output logic       first_err,
  output logic       drop_err
);

  typedef enum logic [1:0] {F0 = 2'd0, F1 = 2'd1, F2 = 2'd2, F3 = 2'd3} state_t;

  state_t     state;
  logic [7:0] asm_vec;
  logic       accept;
  logic       resync;
  logic       drop;

  // Merge one field into the partial vector at the bit position its index selects.
  function automatic logic [7:0] place_field(input logic [7:0] cur, input logic [1:0] idx,
                                             input logic [3:0] d);
    logic [7:0] r;
    r = cur;
    case (idx)
      2'd0:    r[7:4] = d;
      2'd1:    r[3:2] = d[1:0];
      2'd2:    r[1]   = d[0];
      default: r[0]   = d[0];
    endcase
    return r;
  endfunction

  // Only the last field stalls, and only when the output word cannot drain.
  assign fld_ready = rst_n && !(state == F3 && out_valid && !out_ready);
  assign accept    = fld_valid && fld_ready;
  assign resync    = CHECK_FIRST && fld_first && (state != F0);
  assign drop      = CHECK_FIRST && !fld_first && (state == F0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= F0;
      asm_vec   <= 8'h00;
      out_vec   <= 8'h00;
      out_valid <= 1'b0;
      first_err <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      first_err <= 1'b0;
      drop_err  <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        if (resync) begin
          asm_vec   <= place_field(asm_vec, 2'd0, fld_data);
          state     <= F1;
          first_err <= 1'b1;
        end else if (drop) begin
          drop_err <= 1'b1;
        end else begin
          asm_vec <= place_field(asm_vec, state, fld_data);
          if (state == F3) begin
            out_vec   <= {asm_vec[7:1], fld_data[0]};
            out_valid <= 1'b1;
            state     <= F0;
          end else begin
            state <= state_t'(state + 2'd1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_assembler.sv
// Self-checking bench for vector_assembler: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_vector_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fld_valid = 1'b0;
  logic [3:0] fld_data = 4'h0;
  logic       fld_first = 1'b0;
  logic       fld_ready;
  logic       out_valid;
  logic [7:0] out_vec;
  logic       out_ready = 1'b1;
  logic       first_err;
  logic       drop_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] part[$];
  logic       m_ovalid = 1'b0;
  logic [7:0] m_ovec   = 8'h00;
  logic       m_ferr   = 1'b0;
  logic       m_derr   = 1'b0;

  vector_assembler #(.CHECK_FIRST(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fld_valid (fld_valid),
    .fld_data  (fld_data),
    .fld_first (fld_first),
    .fld_ready (fld_ready),
    .out_valid (out_valid),
    .out_vec   (out_vec),
    .out_ready (out_ready),
    .first_err (first_err),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were presented.
  task automatic model_edge(input logic v, input logic [3:0] d, input logic f,
                            input logic ordy, input logic rn, input logic rdy);
    logic [3:0] p0, p1, p2;
    m_ferr = 1'b0;
    m_derr = 1'b0;
    if (!rn) begin
      part.delete();
      m_ovalid = 1'b0;
      m_ovec   = 8'h00;
      return;
    end
    if (m_ovalid && ordy) m_ovalid = 1'b0;
    if (v && rdy) begin
      if (f && part.size() != 0) begin
        part.delete();
        part.push_back(d);
        m_ferr = 1'b1;
      end else if (!f && part.size() == 0) begin
        m_derr = 1'b1;
      end else if (part.size() == 3) begin
        p0 = part[0];
        p1 = part[1];
        p2 = part[2];
        m_ovec   = {p0, p1[1:0], p2[0], d[0]};
        m_ovalid = 1'b1;
        part.delete();
      end else begin
        part.push_back(d);
      end
    end
  endtask

  // One clock cycle: drive, check combinational ready, clock, check registered outputs.
  task automatic step(input logic v, input logic [3:0] d, input logic f,
                      input logic ordy, input logic rn, output logic rdy);
    logic exp_rdy;
    fld_valid = v;
    fld_data  = d;
    fld_first = f;
    out_ready = ordy;
    rst_n     = rn;
    #1;
    exp_rdy = rn && !(part.size() == 3 && m_ovalid && !ordy);
    rdy = fld_ready;
    check_val("fld_ready", {31'd0, fld_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    model_edge(v, d, f, ordy, rn, exp_rdy);
    @(negedge clk);
    check_val("out_valid", {31'd0, out_valid}, {31'd0, m_ovalid});
    if (m_ovalid || !rn) check_val("out_vec", {24'd0, out_vec}, {24'd0, m_ovec});
    check_val("first_err", {31'd0, first_err}, {31'd0, m_ferr});
    check_val("drop_err", {31'd0, drop_err}, {31'd0, m_derr});
  endtask

  initial begin
    logic r;
    logic v, f, ordy, rn;
    logic [3:0] d;

    // Reset
    step(0, 4'h0, 0, 1, 0, r);
    step(0, 4'h0, 0, 1, 0, r);
    check_val("rst_vec", {24'd0, out_vec}, 32'h0);
    check_val("rst_ready", {31'd0, r}, 32'h0);
    step(0, 4'h0, 0, 1, 1, r);
    check_val("ready_after_rst", {31'd0, r}, 32'h1);

    // Basic assembly
    step(1, 4'hD, 1, 1, 1, r);
    step(1, 4'h1, 0, 1, 1, r);
    step(1, 4'h1, 0, 1, 1, r);
    check_val("basic_not_yet", {31'd0, out_valid}, 32'h0);
    step(1, 4'h0, 0, 1, 1, r);
    check_val("basic_valid", {31'd0, out_valid}, 32'h1);
    check_val("basic_vec", {24'd0, out_vec}, 32'hD6);

    // High bits ignored, field 1 not reversed
    step(1, 4'h2, 1, 1, 1, r);
    step(1, 4'b1101, 0, 1, 1, r);
    step(1, 4'b1110, 0, 1, 1, r);
    step(1, 4'b0001, 0, 1, 1, r);
    check_val("order_vec", {24'd0, out_vec}, 32'h25);

    // Backpressure
    step(0, 4'h0, 0, 1, 1, r);
    step(1, 4'h8, 1, 0, 1, r);
    step(1, 4'h0, 0, 0, 1, r);
    step(1, 4'h0, 0, 0, 1, r);
    step(1, 4'h1, 0, 0, 1, r);
    step(1, 4'h3, 1, 0, 1, r);
    step(1, 4'h3, 0, 0, 1, r);
    step(1, 4'h0, 0, 0, 1, r);
    step(1, 4'h0, 0, 0, 1, r);
    check_val("bp_stall", {31'd0, r}, 32'h0);
    check_val("bp_hold", {24'd0, out_vec}, 32'h81);
    step(1, 4'h0, 0, 1, 1, r);
    check_val("bp_accept", {31'd0, r}, 32'h1);
    check_val("bp_valid", {31'd0, out_valid}, 32'h1);
    check_val("bp_vec", {24'd0, out_vec}, 32'h3C);

    // Resync on unexpected first
    step(0, 4'h0, 0, 1, 1, r);
    step(1, 4'hA, 1, 1, 1, r);
    step(1, 4'h3, 0, 1, 1, r);
    step(1, 4'h5, 1, 1, 1, r);
    check_val("resync_ferr", {31'd0, first_err}, 32'h1);
    step(1, 4'h0, 0, 1, 1, r);
    check_val("resync_pulse", {31'd0, first_err}, 32'h0);
    step(1, 4'h1, 0, 1, 1, r);
    step(1, 4'h1, 0, 1, 1, r);
    check_val("resync_vec", {24'd0, out_vec}, 32'h53);

    // Drop an unframed field
    step(0, 4'h0, 0, 1, 1, r);
    step(1, 4'h7, 0, 1, 1, r);
    check_val("drop_derr", {31'd0, drop_err}, 32'h1);
    check_val("drop_nvalid", {31'd0, out_valid}, 32'h0);
    step(1, 4'h9, 1, 1, 1, r);
    step(1, 4'h1, 0, 1, 1, r);
    step(1, 4'h1, 0, 1, 1, r);
    step(1, 4'h0, 0, 1, 1, r);
    check_val("drop_next_vec", {24'd0, out_vec}, 32'h96);

    // Reset mid-vector
    step(1, 4'h4, 1, 1, 1, r);
    step(1, 4'h2, 0, 1, 1, r);
    step(0, 4'h0, 0, 1, 0, r);
    check_val("midrst_valid", {31'd0, out_valid}, 32'h0);
    check_val("midrst_vec", {24'd0, out_vec}, 32'h0);
    step(1, 4'hF, 1, 1, 1, r);
    step(1, 4'h3, 0, 1, 1, r);
    step(1, 4'h1, 0, 1, 1, r);
    step(1, 4'h1, 0, 1, 1, r);
    check_val("midrst_ff", {24'd0, out_vec}, 32'hFF);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      d    = 4'($urandom);
      f    = (part.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      rn   = ($urandom_range(0, 79) != 0);
      step(v, d, f, ordy, rn, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_assembler.md
# vector_assembler

Sequential field-to-vector assembler: the inverse of the 8-bit field splitter. Accepts four framed fields over a valid/ready stream (4-bit, 2-bit, 1-bit, 1-bit, in that order) and rebuilds the 8-bit vector `out_vec`. The vector is presented on a registered valid/ready output with one-word buffering. Sits at the receive end of any path that carries a vector as split fields, e.g. a narrow serial link or a per-field register-write path.

## Interface
- `CHECK_FIRST`, default 1: 1 enforces `fld_first` framing and drives both error pulses; 0 ignores `fld_first` and holds `first_err`/`drop_err` at 0.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; **one clock; reset is synchronous and active-low**.
- `fld_valid`  in  1  field present on `fld_data`.
- `fld_data`  in  4  field payload, LSB-aligned.
- `fld_first`  in  1  marks field 0 of a vector.
- `fld_ready`  out  1  block can accept a field this cycle.
- `out_valid`  out  1  `out_vec` holds an assembled vector.
- `out_vec`  out  8  assembled vector.
- `out_ready`  in  1  downstream consumes `out_vec`.
- `first_err`  out  1  one-cycle pulse: the block discarded a partial vector.
- `drop_err`  out  1  one-cycle pulse: the block dropped an unframed field.

## Operation
- A field is accepted when `fld_valid && fld_ready` at the clock edge.
- Field index `idx[1:0]` selects the destination of each accepted field. Bit order is preserved, never reversed:
  - idx 0: `asm[7:4] <= fld_data[3:0]`
  - idx 1: `asm[3:2] <= fld_data[1:0]`
  - idx 2: `asm[1] <= fld_data[0]`
  - idx 3: `asm[0] <= fld_data[0]`
- Unused `fld_data` bits are ignored.
- State machine, 4 states `F0`→`F1`→`F2`→`F3`→`F0`. The state equals `idx`. Each accepted field advances the state by one.
- On acceptance at `F3`: `out_vec[7:1] <= asm[7:1]`, `out_vec[0] <= fld_data[0]`, `out_valid <= 1`, state returns to `F0`.
- Output hand-off: `out_valid && out_ready` consumes the word. `out_valid` clears unless a new word loads in the same cycle.
- `fld_ready = rst_n && !(state==F3 && out_valid && !out_ready)`. This is combinational from `out_ready`.
  - Fields 0–2 are always accepted.
  - Only the final field stalls, and only while the output buffer is occupied and not draining.

Framing rules when `CHECK_FIRST=1`:
- `fld_first=1` accepted in `F1`..`F3`: the partial vector is discarded, the field is stored as field 0, the state goes to `F1`, and `first_err` pulses.
- `fld_first=0` accepted in `F0`: the field is consumed and dropped, the state stays `F0`, and `drop_err` pulses.
- `fld_first=1` in `F0`: normal.

Reset behaviour:
- While `rst_n` is low: `out_vec=8'h00`, `out_valid=0`, `asm=8'h00`, state `F0`, `fld_ready=0`, both error outputs 0.
- Reset asserted mid-vector discards the partial vector and any unconsumed output word.

## Timing
- Latency: `out_valid` rises the cycle after the edge that accepts field 3.
- Throughput: one field per cycle, so one vector per 4 cycles with no bubbles while `out_ready=1`.
- Simultaneous consume and load (`out_valid && out_ready` plus field-3 acceptance in one cycle): `out_vec` takes the new word and `out_valid` stays 1.
- `out_vec` and `out_valid` are stable while `out_valid && !out_ready`.
- Error pulses are registered. Each is high for exactly the one cycle after the offending field's acceptance edge.
- `fld_ready` is high in the first cycle after `rst_n` deasserts.

## Test plan
- **Basic assembly:** fields 0xD (`fld_first`=1), 0x1, 0x1, 0x0 on consecutive cycles with `out_ready=1` → `out_vec=8'hD6`, `out_valid` high one cycle after field 3, no errors.
- **Ignored high bits and ordering:** fields 0x2 (first), 4'b1101, 4'b1110, 4'b0001 → `out_vec=8'b0010_0101` (0x25). This proves field 1 maps to bits [3:2] unreversed.
- **Backpressure:** `out_ready=0`, assemble 0x81, then fields 0–2 of 0x3C.
  - Field 3 sees `fld_ready=0`, and `out_vec` holds 0x81.
  - Raise `out_ready` → 0x81 consumed and 0x3C loads in the same cycle, with `out_valid` continuously 1.
- **Resync:** fields 0xA (first), 0x3, then 0x5 with `fld_first`=1, 0x0, 0x1, 0x1 → `first_err` pulses once, `out_vec=8'h53`.
- **Drop:** with `out_valid=0`, send 0x7 with `fld_first`=0 in `F0` → `drop_err` pulses once, no `out_valid`, and the next framed vector assembles correctly.
- **Reset mid-vector:** accept 2 fields, assert `rst_n=0` for 1 cycle → all outputs zero, then a full vector 0xFF assembles to `out_vec=8'hFF`.
